capture_dump: RTL and testbench

- Read-side counterpart of the ADC capture writer.
- On a dump command, reads one channel's 512-entry circular capture RAM in chronological order, starting at the oldest sample (trace_end+1) and ending at trace_end.
- Streams the samples as bytes to the host transmitter over a valid/ready handshake.
- Pulses dump_fin when the last byte is accepted; this is the signal the capture controller waits on in its DUMP state.

---
 rtl/capture_pkg.sv | 20 ++
 rtl/capture_dump_addr_gen.sv | 35 +++
 rtl/capture_dump.sv | 140 ++++++++++++++
 tb/tb_capture_dump.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared constants and state encoding for the ADC capture writer and dump reader.
package capture_pkg;

  localparam int CAP_ADDR_W = 9;
  localparam int CAP_DEPTH  = 1 << CAP_ADDR_W;
  localparam int CAP_NUM_CH = 3;
  localparam int CAP_DATA_W = 8;

  localparam logic [7:0] HDR_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    XMIT,
    FIN,
    HDR
  } dump_state_t;

endpackage

// File: rtl/capture_dump_addr_gen.sv
// Read pointer and sample counter for the capture dump; the pointer wraps at
// the RAM depth so a dump starting past the newest sample walks oldest-first.
module dump_addr_gen
  import capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              done
);

  logic [ADDR_W:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (load) begin
      rd_ptr <= start_addr + ADDR_W'(1);
      cnt    <= '0;
    end else if (advance) begin
      rd_ptr <= rd_ptr + ADDR_W'(1);
      cnt    <= cnt + (ADDR_W + 1)'(1);
    end
  end

  // High while the sample being sent is the last of the full buffer.
  assign done = (cnt == (ADDR_W + 1)'((1 << ADDR_W) - 1));

endmodule

// File: rtl/capture_dump.sv
// Streams one channel's circular capture RAM to the host transmitter, oldest
// sample first. Build with CAPTURE_DUMP_HEADER_EN to prefix a 2-byte header.
//
// state | meaning
// IDLE  | waiting for a dump command
// HDR   | presenting a header byte (sync, then channel)
// RD    | read strobe to the selected RAM
// LAT   | RAM data returning, loaded into tx_data
// XMIT  | byte offered to the transmitter until accepted
// FIN   | one-cycle dump_fin pulse
module capture_dump
  import capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DATA_W = CAP_DATA_W,
  parameter int NUM_CH = CAP_NUM_CH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump,
  input  logic [1:0]        ch_sel,
  input  logic [ADDR_W-1:0] trace_end,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [NUM_CH-1:0] ram_en,
  input  logic [DATA_W-1:0] ram_rdata0,
  input  logic [DATA_W-1:0] ram_rdata1,
  input  logic [DATA_W-1:0] ram_rdata2,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              dumping,
  output logic              dump_fin
);

  dump_state_t       state, state_nxt;
  logic [1:0]        ch_q;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] rdata_sel;
  logic [NUM_CH-1:0] ch_onehot;
  logic              load, advance, done, ch_sel_ok;

  assign load      = (state == IDLE) && dump;
  assign advance   = (state == XMIT) && tx_ready;
  assign ch_sel_ok = int'(ch_sel) < NUM_CH;
  assign ch_onehot = NUM_CH'(1) << ch_q;

  dump_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .start_addr (trace_end),
    .advance    (advance),
    .rd_ptr     (rd_ptr),
    .done       (done)
  );

`ifdef CAPTURE_DUMP_HEADER_EN
  logic hdr_idx;
  logic ch_ok;

  assign ch_ok = int'(ch_q) < NUM_CH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hdr_idx <= 1'b0;
    else if (load)
      hdr_idx <= 1'b0;
    else if (state == HDR && tx_ready)
      hdr_idx <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dump) begin
`ifdef CAPTURE_DUMP_HEADER_EN
          state_nxt = HDR;
`else
          state_nxt = ch_sel_ok ? RD : FIN;
`endif
        end
      end
`ifdef CAPTURE_DUMP_HEADER_EN
      HDR:     if (tx_ready && hdr_idx) state_nxt = ch_ok ? RD : FIN;
`endif
      RD:      state_nxt = LAT;
      LAT:     state_nxt = XMIT;
      XMIT:    if (tx_ready) state_nxt = done ? FIN : RD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata_sel = '0;
    case (ch_q)
      2'd0:    rdata_sel = ram_rdata0;
      2'd1:    rdata_sel = ram_rdata1;
      2'd2:    rdata_sel = ram_rdata2;
      default: rdata_sel = '0;
    endcase
  end

  // tx_data only changes outside an offered byte, so it is stable while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      tx_data <= '0;
    end else begin
      if (load) begin
        ch_q <= ch_sel;
`ifdef CAPTURE_DUMP_HEADER_EN
        tx_data <= DATA_W'(HDR_SYNC);
`endif
      end
`ifdef CAPTURE_DUMP_HEADER_EN
      if (state == HDR && tx_ready && !hdr_idx)
        tx_data <= DATA_W'(ch_q);
`endif
      if (state == LAT)
        tx_data <= rdata_sel;
    end
  end

  assign ram_addr = rd_ptr;
  assign ram_en   = (state == RD) ? ch_onehot : '0;
  assign tx_valid = (state == XMIT) || (state == HDR);
  assign dumping  = (state != IDLE);
  assign dump_fin = (state == FIN);

endmodule

// File: tb/tb_capture_dump.sv
// Directed bench for capture_dump; works with or without CAPTURE_DUMP_HEADER_EN.
module tb_capture_dump;

  localparam int DEPTH = 512;
`ifdef CAPTURE_DUMP_HEADER_EN
  localparam int HN       = 2;
  localparam int LAT_EXP  = 0;
  localparam int FIN_ILL  = 2;
`else
  localparam int HN       = 0;
  localparam int LAT_EXP  = 2;
  localparam int FIN_ILL  = 0;
`endif

  logic       clk, rst_n, dump, tx_ready;
  logic [1:0] ch_sel;
  logic [8:0] trace_end, ram_addr;
  logic [2:0] ram_en;
  logic [7:0] ram_rdata0, ram_rdata1, ram_rdata2, tx_data;
  logic       tx_valid, dumping, dump_fin;

  capture_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump       (dump),
    .ch_sel     (ch_sel),
    .trace_end  (trace_end),
    .ram_addr   (ram_addr),
    .ram_en     (ram_en),
    .ram_rdata0 (ram_rdata0),
    .ram_rdata1 (ram_rdata1),
    .ram_rdata2 (ram_rdata2),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .dumping    (dumping),
    .dump_fin   (dump_fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem0 [DEPTH];
  logic [7:0] mem1 [DEPTH];
  logic [7:0] mem2 [DEPTH];

  always @(posedge clk) begin
    if (ram_en[0]) ram_rdata0 <= mem0[ram_addr];
    if (ram_en[1]) ram_rdata1 <= mem1[ram_addr];
    if (ram_en[2]) ram_rdata2 <= mem2[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [8:0] rd_q[$];
  logic [2:0] exp_en;
  int   en_bad, stab_viol, hold_cnt, fin_cnt, fin_cyc, last_acc_cyc;
  int   first_valid, first_dumping, valid_cnt;
  logic after_fin_dumping, prev_hold, prev_fin;
  logic [7:0] prev_data;

  // Passive observer on the falling edge, where all DUT outputs are settled.
  always @(negedge clk) begin
    if (ram_en != 3'b000) begin
      rd_q.push_back(ram_addr);
      if (ram_en != exp_en) en_bad++;
    end
    if (tx_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (dumping && first_dumping < 0) first_dumping = cyc;
    if (prev_hold) begin
      hold_cnt++;
      if (!(tx_valid && tx_data == prev_data)) stab_viol++;
    end
    if (tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      last_acc_cyc = cyc;
    end
    if (prev_fin) after_fin_dumping = dumping;
    if (dump_fin) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
    prev_hold = tx_valid && !tx_ready;
    prev_data = tx_data;
    prev_fin  = dump_fin;
  end

  task automatic clear_mon();
    rx_q.delete();
    rd_q.delete();
    en_bad = 0; stab_viol = 0; hold_cnt = 0; fin_cnt = 0; fin_cyc = -1;
    last_acc_cyc = -1; first_valid = -1; first_dumping = -1; valid_cnt = 0;
    after_fin_dumping = 1'b1; prev_hold = 1'b0; prev_fin = 1'b0;
  endtask

  task automatic build_exp(input int ch, input logic [8:0] te);
    logic [8:0] a;
    exp_q.delete();
    if (HN > 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(ch));
    end
    if (ch < 3) begin
      a = te;
      for (int k = 0; k < DEPTH; k++) begin
        a = a + 9'd1;
        case (ch)
          0:       exp_q.push_back(mem0[a]);
          1:       exp_q.push_back(mem1[a]);
          default: exp_q.push_back(mem2[a]);
        endcase
      end
    end
  endtask

  function automatic int seq_diff();
    int b = 0;
    int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (rx_q[i] !== exp_q[i]) b++;
    b += (rx_q.size() > exp_q.size()) ? rx_q.size() - exp_q.size()
                                      : exp_q.size() - rx_q.size();
    return b;
  endfunction

  task automatic start_dump(input logic [1:0] ch, input logic [8:0] te);
    @(posedge clk); #1;
    clear_mon();
    dump = 1'b1; ch_sel = ch; trace_end = te;
    @(posedge clk); #1;
    dump = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dumping && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL dump_timeout: still dumping after %0d cycles, required done", n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dump = 1'b0; ch_sel = 2'd0; trace_end = 9'd0; tx_ready = 1'b1;
    exp_en = 3'b001;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ram_addr, ram_en, tx_data, tx_valid, dumping, dump_fin} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d en=%b data=%h v=%b dumping=%b fin=%b, required all 0",
               ram_addr, ram_en, tx_data, tx_valid, dumping, dump_fin);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_ch0_full();
    tx_ready = 1'b1; exp_en = 3'b001;
    build_exp(0, 9'd100);
    start_dump(2'd0, 9'd100);
    wait_done(5000);
    checks++; if (rx_q.size() !== DEPTH + HN) begin errors++;
      $display("FAIL ch0_count: got %0d bytes, required %0d", rx_q.size(), DEPTH + HN); end
    checks++; if (seq_diff() !== 0) begin errors++;
      $display("FAIL ch0_sequence: %0d mismatched bytes, required 0", seq_diff()); end
`ifdef CAPTURE_DUMP_HEADER_EN
    checks++; if (rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h00) begin errors++;
      $display("FAIL ch0_header: got %h %h, required a5 00", rx_q[0], rx_q[1]); end
`endif
    checks++; if (rx_q[HN] !== 8'd101) begin errors++;
      $display("FAIL ch0_first: got %h, required %h", rx_q[HN], 8'd101); end
    checks++; if (rx_q[HN+410] !== 8'hFF || rx_q[HN+411] !== 8'h00) begin errors++;
      $display("FAIL ch0_wrap: got %h %h, required ff 00", rx_q[HN+410], rx_q[HN+411]); end
    checks++; if (rx_q[HN+511] !== 8'd100) begin errors++;
      $display("FAIL ch0_last: got %h, required %h", rx_q[HN+511], 8'd100); end
    checks++; if (fin_cnt !== 1) begin errors++;
      $display("FAIL ch0_fin_count: got %0d, required 1", fin_cnt); end
    checks++; if (fin_cyc !== last_acc_cyc + 1) begin errors++;
      $display("FAIL ch0_fin_timing: fin cycle %0d, required %0d", fin_cyc, last_acc_cyc + 1); end
    checks++; if (after_fin_dumping !== 1'b0) begin errors++;
      $display("FAIL ch0_dumping_after_fin: got %b, required 0", after_fin_dumping); end
    checks++; if (first_valid - first_dumping !== LAT_EXP) begin errors++;
      $display("FAIL ch0_latency: got %0d, required %0d", first_valid - first_dumping, LAT_EXP); end
  endtask

  task automatic test_ch2_wrap();
    tx_ready = 1'b1; exp_en = 3'b100;
    build_exp(2, 9'd511);
    start_dump(2'd2, 9'd511);
    wait_done(5000);
    checks++; if (rd_q.size() !== DEPTH) begin errors++;
      $display("FAIL ch2_reads: got %0d reads, required %0d", rd_q.size(), DEPTH); end
    checks++; if (rd_q[0] !== 9'd0) begin errors++;
      $display("FAIL ch2_first_addr: got %0d, required 0", rd_q[0]); end
    checks++; if (rd_q[rd_q.size()-1] !== 9'd511) begin errors++;
      $display("FAIL ch2_last_addr: got %0d, required 511", rd_q[rd_q.size()-1]); end
    checks++; if (rx_q[HN] !== 8'hFF) begin errors++;
      $display("FAIL ch2_first_byte: got %h, required ff", rx_q[HN]); end
    checks++; if (en_bad !== 0) begin errors++;
      $display("FAIL ch2_ram_en: %0d strobes other than 100, required 0", en_bad); end
    checks++; if (seq_diff() !== 0) begin errors++;
      $display("FAIL ch2_sequence: %0d mismatched bytes, required 0", seq_diff()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    exp_en = 3'b001;
    tx_ready = 1'b0;
    build_exp(0, 9'd100);
    start_dump(2'd0, 9'd100);
    while (dumping && n < 20000) begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 9) < 3);
      n++;
    end
    tx_ready = 1'b1;
    checks++; if (n >= 20000) begin errors++;
      $display("FAIL bp_timeout: still dumping after %0d cycles, required done", n); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (seq_diff() !== 0) begin errors++;
      $display("FAIL bp_sequence: %0d mismatched bytes (got %0d bytes), required 0", seq_diff(), rx_q.size()); end
    checks++; if (stab_viol !== 0 || hold_cnt == 0) begin errors++;
      $display("FAIL bp_stable: %0d violations over %0d stalls, required 0 over >0", stab_viol, hold_cnt); end
    checks++; if (fin_cnt !== 1) begin errors++;
      $display("FAIL bp_fin_count: got %0d, required 1", fin_cnt); end
  endtask

  task automatic test_illegal();
    tx_ready = 1'b1; exp_en = 3'b000;
    build_exp(3, 9'd50);
    start_dump(2'd3, 9'd50);
    wait_done(100);
    checks++; if (rd_q.size() !== 0) begin errors++;
      $display("FAIL ill_reads: got %0d reads, required 0", rd_q.size()); end
    checks++; if (valid_cnt !== HN || seq_diff() !== 0) begin errors++;
      $display("FAIL ill_bytes: got %0d valid cycles, %0d mismatches, required %0d and 0", valid_cnt, seq_diff(), HN); end
    checks++; if (fin_cnt !== 1 || fin_cyc - first_dumping !== FIN_ILL) begin errors++;
      $display("FAIL ill_fin: got count %0d offset %0d, required 1 and %0d", fin_cnt, fin_cyc - first_dumping, FIN_ILL); end
  endtask

  task automatic test_ignore_dump();
    tx_ready = 1'b1; exp_en = 3'b010;
    build_exp(1, 9'd200);
    start_dump(2'd1, 9'd200);
    repeat (60) @(posedge clk);
    #1;
    dump = 1'b1; ch_sel = 2'd0; trace_end = 9'd5;
    @(posedge clk); #1;
    dump = 1'b0;
    wait_done(5000);
    checks++; if (rx_q.size() !== DEPTH + HN) begin errors++;
      $display("FAIL ign_count: got %0d bytes, required %0d", rx_q.size(), DEPTH + HN); end
    checks++; if (seq_diff() !== 0 || en_bad !== 0) begin errors++;
      $display("FAIL ign_sequence: %0d mismatches, %0d bad strobes, required 0 and 0", seq_diff(), en_bad); end
    checks++; if (fin_cnt !== 1) begin errors++;
      $display("FAIL ign_fin_count: got %0d, required 1", fin_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    tx_ready = 1'b1; exp_en = 3'b001;
    build_exp(0, 9'd100);
    start_dump(2'd0, 9'd100);
    while (rx_q.size() < HN + 200 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ram_addr, ram_en, tx_data, tx_valid, dumping, dump_fin} !== 23'd0) begin errors++;
      $display("FAIL mid_async_reset: got addr=%0d en=%b data=%h v=%b dumping=%b fin=%b, required all 0",
               ram_addr, ram_en, tx_data, tx_valid, dumping, dump_fin); end
    repeat (3) @(posedge clk);
    checks++; if (fin_cnt !== 0 || rx_q.size() !== HN + 200) begin errors++;
      $display("FAIL mid_abort: got fin %0d bytes %0d, required 0 and %0d", fin_cnt, rx_q.size(), HN + 200); end
    @(negedge clk) rst_n = 1'b1;
    build_exp(0, 9'd300);
    start_dump(2'd0, 9'd300);
    wait_done(5000);
    checks++; if (rx_q[HN] !== 8'h2D) begin errors++;
      $display("FAIL mid_restart_first: got %h, required 2d", rx_q[HN]); end
    checks++; if (seq_diff() !== 0 || fin_cnt !== 1) begin errors++;
      $display("FAIL mid_restart_seq: %0d mismatches fin %0d, required 0 and 1", seq_diff(), fin_cnt); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem0[i] = 8'(i);
      mem1[i] = 8'(i * 3 + 7);
      mem2[i] = ~8'(i);
    end
    test_reset();
    test_ch0_full();
    test_ch2_wrap();
    test_backpressure();
    test_illegal();
    test_ignore_dump();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
